issue_buffer: RTL and testbench
===============================

# issue_buffer

Circular instruction queue between IF and ID of the 3-way in-order superscalar pipeline, and the consumer of the `rollback` count from the hazard detection unit. It presents the three oldest fetched instructions to ID each cycle. At the clock edge it retires only the ways that actually issued, so rolled-back ways are presented again as the oldest ways of the next bundle. Fetch pushes up to three instructions per cycle when space allows, and a flush empties the queue.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 6.

Ports:
- `clock`, input, 1: the only clock.
- `reset`, input, 1: synchronous, active-high.
- `flush`, input, 1: squash all queued instructions (branch mispredict).
- `stall`, input, 1: downstream structural stall; nothing issues this cycle.
- `rollback`, input, 2: number of youngest presented ways that did not issue (0..3), from the detection unit.
- `if_packet_0`, `if_packet_1`, `if_packet_2`, input, IF_ID_PACKET: fetch bundle, oldest first. Valid bits form a prefix, so a valid way is never preceded by an invalid one.
- `fetch_ready`, output, 1: the queue accepts a fetch bundle this cycle.
- `id_packet_0`, `id_packet_1`, `id_packet_2`, output, IF_ID_PACKET: the three oldest entries, oldest in way 0.
- `count`, output, $clog2(DEPTH)+1: current occupancy.

## Operation
- State: `head` and `tail` pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH; `count`, 0..DEPTH; entry array of IF_ID_PACKET.
- Presentation (combinational from registers):
  - `id_packet_k` = entry[(head+k) mod DEPTH] with valid=1 when k < count.
  - Otherwise `id_packet_k` is a NOP packet with valid=0.
  - `out_n` = min(count, 3).
- Issue count:
  - `pop` = 0 if `stall`.
  - Otherwise `pop` = min(out_n, 3 − rollback).
  - rollback=3 gives pop=0.
  - Rollback beyond the valid ways retires every valid way, e.g. count=1, rollback=2 gives pop=1.
- `fetch_ready` = (count ≤ DEPTH−3). It depends on registers only and never on `rollback`.
- Push:
  - `push` = number of valid `if_packet` ways when `fetch_ready`, else 0.
  - Way k is written to entry[(tail+k) mod DEPTH].
  - When `fetch_ready`=0 the bundle is dropped by the buffer; fetch must hold its PC.
- Update at the edge:
  - head ← head+pop
  - tail ← tail+push
  - count ← count+push−pop
  - Push and pop in the same cycle are legal.
  - count never exceeds DEPTH and never goes negative.
- Flush: head ← 0, tail ← 0, count ← 0. Flush overrides push and pop in the same cycle; the fetch bundle in that cycle is discarded.
- Reset has identical effect to flush and takes priority over all other inputs. Reset in the middle of a rollback sequence discards every held instruction.
- Ordering: the relative order of instructions is always preserved. A rolled-back way k (k ≥ 3−rollback) is presented next cycle at way k−(3−rollback).

## Timing
- Reset values:
  - count=0
  - fetch_ready=1
  - all `id_packet_k` valid=0 (NOP)
  - head=tail=0
- Latency: an instruction pushed at edge N appears on `id_packet_*` in cycle N+1 when fewer than 3 older entries remain. This is one cycle, matching the old IF/ID register.
- `rollback` and `stall` are sampled only at the clock edge. The presented bundle is stable for the whole cycle.
- `fetch_ready` changes only after an edge.
- Flush effect: outputs are invalid in the cycle after the flush edge; the first refetched bundle appears one cycle later.
- Throughput: 3 instructions/cycle sustained with rollback=0 and continuous fetch.

## Test plan
- Reset, then push I0..I2 (PC 0,4,8) with rollback=0 → next cycle `id_packet_0..2` PCs 0,4,8 valid, count=3. After one edge with no push, count=0 and all outputs invalid.
- Six entries queued (PC 0..20), rollback=1 → next cycle ways show PCs 8,12,16 and count=4. Then rollback=3 → same bundle held, count unchanged.
- count=6, push 3 valid → `fetch_ready`=0 and the bundle is not written, count=6. The same cycle with rollback=0 gives count=3, and `fetch_ready`=1 after the edge.
- Wrap-around: advance head/tail past DEPTH−1 over 4 cycles of push 3 / pop 3 → output PCs stay in order across index 7→0.
- count=1, rollback=2 → pop=1, count=0. `stall`=1 with rollback=0 → pop=0.
- `flush`=1 with push 3 and rollback=0 at count=5 → next cycle count=0, all outputs invalid, `fetch_ready`=1. Assert `reset` during a held rollback → same result.

Source files
------------

// File: rtl/issue_buffer_if.sv
// Packet type and the IF/ID-side bundle of the issue buffer.
// The pipeline (fetch + decode + hazard unit) is the master; the buffer is the slave.
package issue_buffer_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } IF_ID_PACKET;

  localparam IF_ID_PACKET NOP_PACKET = '{inst: 32'h0000_0013, pc: '0, npc: '0, valid: 1'b0};
endpackage

interface issue_buffer_if #(parameter int DEPTH = 8);
  import issue_buffer_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          stall;
  logic [1:0]    rollback;
  IF_ID_PACKET   if_packet_0, if_packet_1, if_packet_2;
  logic          fetch_ready;
  IF_ID_PACKET   id_packet_0, id_packet_1, id_packet_2;
  logic [CW-1:0] count;

  modport master (
    output flush, stall, rollback, if_packet_0, if_packet_1, if_packet_2,
    input  fetch_ready, id_packet_0, id_packet_1, id_packet_2, count
  );
  modport slave (
    input  flush, stall, rollback, if_packet_0, if_packet_1, if_packet_2,
    output fetch_ready, id_packet_0, id_packet_1, id_packet_2, count
  );
endinterface

// File: rtl/issue_buffer.sv
// Circular IF->ID instruction queue: presents the 3 oldest entries, retires only
// the ways that issued (3 - rollback), and accepts up to 3 fetched ways per cycle.

// One presentation way: the entry at head+LANE, or a NOP when that slot is empty.
module ib_way
  import issue_buffer_pkg::*;
#(
  parameter int LANE = 0,
  parameter int CW   = 4
) (
  input  IF_ID_PACKET   entry,
  input  logic [CW-1:0] cnt,
  output IF_ID_PACKET   pkt
);
  always_comb begin
    pkt = NOP_PACKET;
    if (cnt > CW'(LANE)) begin
      pkt       = entry;
      pkt.valid = 1'b1;
    end
  end
endmodule

module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  issue_buffer_if.slave bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = 3;

  IF_ID_PACKET   entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;

  IF_ID_PACKET   if_pkt [LANES];
  IF_ID_PACKET   id_pkt [LANES];
  logic [1:0]    out_n, avail, pop, push;
  logic          fetch_ready;

  assign if_pkt[0] = bus.if_packet_0;
  assign if_pkt[1] = bus.if_packet_1;
  assign if_pkt[2] = bus.if_packet_2;

  assign bus.id_packet_0 = id_pkt[0];
  assign bus.id_packet_1 = id_pkt[1];
  assign bus.id_packet_2 = id_pkt[2];
  assign bus.count       = cnt;
  assign bus.fetch_ready = fetch_ready;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_way
      ib_way #(.LANE(k), .CW(CW)) u_way (
        .entry (entries[head + PW'(k)]),
        .cnt   (cnt),
        .pkt   (id_pkt[k])
      );
    end
  endgenerate

  // Readiness is a function of occupancy alone so fetch never waits on the hazard unit.
  assign fetch_ready = (cnt <= CW'(DEPTH - 3));

  always_comb begin
    out_n = (cnt >= CW'(3)) ? 2'd3 : cnt[1:0];
    avail = 2'd3 - bus.rollback;
    pop   = 2'd0;
    if (!bus.stall) pop = (out_n < avail) ? out_n : avail;
    push  = 2'd0;
    if (fetch_ready)
      push = {1'b0, if_pkt[0].valid} + {1'b0, if_pkt[1].valid} + {1'b0, if_pkt[2].valid};
  end

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      cnt  <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && !bus.flush && fetch_ready) begin
      for (int k = 0; k < LANES; k++)
        if (if_pkt[k].valid) entries[tail + PW'(k)] <= if_pkt[k];
    end
  end
endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: each task drives a scenario and checks the
// presented bundle, occupancy and fetch_ready against hand-computed values.
module tb_issue_buffer;
  import issue_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  issue_buffer_if #(.DEPTH(8)) bus ();
  issue_buffer #(.DEPTH(8)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  IF_ID_PACKET id_p [3];
  assign id_p[0] = bus.id_packet_0;
  assign id_p[1] = bus.id_packet_1;
  assign id_p[2] = bus.id_packet_2;

  task automatic set_fetch(input int n, input logic [31:0] base);
    IF_ID_PACKET p [3];
    for (int k = 0; k < 3; k++) begin
      p[k].valid = (k < n);
      p[k].pc    = base + 32'(4 * k);
      p[k].npc   = base + 32'(4 * k + 4);
      p[k].inst  = 32'hA000_0000 | (base + 32'(4 * k));
    end
    bus.if_packet_0 = p[0];
    bus.if_packet_1 = p[1];
    bus.if_packet_2 = p[2];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0; bus.stall = 1'b0; bus.rollback = 2'd0;
    set_fetch(0, 0);
    step(); step();
    reset = 1'b0;
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_chk++;
    if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.fetch_ready); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid way%0d got %b want 0", k, id_p[k].valid); end
    end
  endtask

  task automatic test_basic();
    set_fetch(3, 32'd0);
    step();
    set_fetch(0, 0);
    n_chk++;
    if (bus.count !== 4'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", bus.count); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b1 || id_p[k].pc !== 32'(4 * k)) begin
        n_fail++; $display("FAIL basic_way%0d got v=%b pc=%0d want v=1 pc=%0d", k, id_p[k].valid, id_p[k].pc, 4 * k);
      end
    end
    step();
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_drain_count got %0d want 0", bus.count); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain way%0d got %b want 0", k, id_p[k].valid); end
    end
  endtask

  task automatic test_rollback();
    set_fetch(3, 32'd0);
    step();
    set_fetch(3, 32'd12);
    bus.rollback = 2'd3;
    step();
    set_fetch(0, 0);
    n_chk++;
    if (bus.count !== 4'd6) begin n_fail++; $display("FAIL rb_fill_count got %0d want 6", bus.count); end
    bus.rollback = 2'd1;
    step();
    n_chk++;
    if (bus.count !== 4'd4) begin n_fail++; $display("FAIL rb1_count got %0d want 4", bus.count); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b1 || id_p[k].pc !== 32'(8 + 4 * k)) begin
        n_fail++; $display("FAIL rb1_way%0d got pc=%0d want %0d", k, id_p[k].pc, 8 + 4 * k);
      end
    end
    bus.rollback = 2'd3;
    step();
    n_chk++;
    if (bus.count !== 4'd4) begin n_fail++; $display("FAIL rb3_count got %0d want 4", bus.count); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b1 || id_p[k].pc !== 32'(8 + 4 * k)) begin
        n_fail++; $display("FAIL rb3_way%0d got pc=%0d want %0d", k, id_p[k].pc, 8 + 4 * k);
      end
    end
  endtask

  // Continues from 4 entries (PC 8..20) holding under rollback=3.
  task automatic test_full();
    set_fetch(2, 32'd24);
    bus.rollback = 2'd3;
    step();
    n_chk++;
    if (bus.count !== 4'd6) begin n_fail++; $display("FAIL full_count got %0d want 6", bus.count); end
    set_fetch(3, 32'd100);
    bus.rollback = 2'd0;
    n_chk++;
    if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.fetch_ready); end
    step();
    set_fetch(0, 0);
    n_chk++;
    if (bus.count !== 4'd3) begin n_fail++; $display("FAIL full_pop_count got %0d want 3", bus.count); end
    n_chk++;
    if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got %b want 1", bus.fetch_ready); end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b1 || id_p[k].pc !== 32'(20 + 4 * k)) begin
        n_fail++; $display("FAIL full_way%0d got pc=%0d want %0d", k, id_p[k].pc, 20 + 4 * k);
      end
    end
    step();
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL full_dropped_count got %0d want 0", bus.count); end
  endtask

  task automatic test_wrap();
    bus.rollback = 2'd0;
    set_fetch(3, 32'd200);
    step();
    for (int i = 1; i <= 4; i++) begin
      set_fetch(3, 32'(200 + 12 * i));
      step();
      n_chk++;
      if (bus.count !== 4'd3) begin n_fail++; $display("FAIL wrap%0d_count got %0d want 3", i, bus.count); end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (id_p[k].valid !== 1'b1 || id_p[k].pc !== 32'(200 + 12 * i + 4 * k)) begin
          n_fail++; $display("FAIL wrap%0d_way%0d got pc=%0d want %0d", i, k, id_p[k].pc, 200 + 12 * i + 4 * k);
        end
      end
    end
    set_fetch(0, 0);
    step();
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wrap_drain_count got %0d want 0", bus.count); end
  endtask

  task automatic test_partial_and_stall();
    set_fetch(1, 32'd300);
    step();
    set_fetch(0, 0);
    n_chk++;
    if (id_p[0].valid !== 1'b1 || id_p[0].pc !== 32'd300 || id_p[1].valid !== 1'b0) begin
      n_fail++; $display("FAIL one_entry got v0=%b pc=%0d v1=%b want 1 300 0", id_p[0].valid, id_p[0].pc, id_p[1].valid);
    end
    bus.rollback = 2'd2;
    step();
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rb2_one_count got %0d want 0", bus.count); end
    bus.rollback = 2'd0;
    set_fetch(2, 32'd400);
    step();
    set_fetch(0, 0);
    bus.stall = 1'b1;
    step();
    n_chk++;
    if (bus.count !== 4'd2) begin n_fail++; $display("FAIL stall_count got %0d want 2", bus.count); end
    n_chk++;
    if (id_p[0].pc !== 32'd400 || id_p[1].pc !== 32'd404 || id_p[2].valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_ways got %0d %0d v2=%b want 400 404 0", id_p[0].pc, id_p[1].pc, id_p[2].valid);
    end
    bus.stall = 1'b0;
    step();
    n_chk++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL stall_release_count got %0d want 0", bus.count); end
  endtask

  task automatic test_flush_reset();
    set_fetch(3, 32'd500);
    bus.rollback = 2'd3;
    step();
    set_fetch(2, 32'd512);
    step();
    n_chk++;
    if (bus.count !== 4'd5) begin n_fail++; $display("FAIL pre_flush_count got %0d want 5", bus.count); end
    bus.flush = 1'b1;
    bus.rollback = 2'd0;
    set_fetch(3, 32'd700);
    step();
    bus.flush = 1'b0;
    n_chk++;
    if (bus.count !== 4'd0 || bus.fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush got count=%0d ready=%b want 0 1", bus.count, bus.fetch_ready);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b0) begin n_fail++; $display("FAIL flush_way%0d got %b want 0", k, id_p[k].valid); end
    end
    set_fetch(3, 32'd600);
    step();
    n_chk++;
    if (id_p[0].valid !== 1'b1 || id_p[0].pc !== 32'd600 || id_p[2].pc !== 32'd608) begin
      n_fail++; $display("FAIL refetch got pc0=%0d pc2=%0d want 600 608", id_p[0].pc, id_p[2].pc);
    end
    bus.rollback = 2'd3;
    set_fetch(0, 0);
    step();
    reset = 1'b1;
    set_fetch(3, 32'd800);
    step();
    reset = 1'b0;
    set_fetch(0, 0);
    n_chk++;
    if (bus.count !== 4'd0 || bus.fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_rb got count=%0d ready=%b want 0 1", bus.count, bus.fetch_ready);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (id_p[k].valid !== 1'b0) begin n_fail++; $display("FAIL reset_rb_way%0d got %b want 0", k, id_p[k].valid); end
    end
    bus.rollback = 2'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rollback();
    test_full();
    test_wrap();
    test_partial_and_stall();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
